// File: rtl/warp_mem_responder.sv
// warp_mem_responder: word-addressed memory model with fixed-latency in-order reads; WARP_MEM_STALL_EN adds LFSR back-pressure
module warp_mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int LATENCY     = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_valid,
  output logic                  mem_req_ready,
  input  logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_write,
  input  logic [31:0]           mem_req_data,
  output logic                  mem_resp_valid,
  input  logic                  mem_resp_ready,
  output logic [31:0]           mem_resp_data,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [31:0]           load_data,
  output logic                  err_oob
);
  localparam int MW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam int QW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [31:0] OOB_WORD = 32'hDEAD_BEEF;
  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   fifo [QUEUE_DEPTH];
  logic [QW-1:0] rp, wp;
  logic [CW-1:0] fcnt, outstanding;
  logic          accept, rd_acc, wr_acc, pop, req_oob, load_oob, stall;
  logic [MW-1:0] req_idx, load_idx;
  logic [31:0]   rd_word, push_d;
  logic          push_v;
  logic          unused_bits;
  assign unused_bits = ^{mem_req_addr[1:0], load_addr[1:0]};
  assign req_oob  = 64'(mem_req_addr[ADDR_WIDTH-1:2]) >= 64'(MEM_DEPTH);
  assign load_oob = 64'(load_addr[ADDR_WIDTH-1:2]) >= 64'(MEM_DEPTH);
  assign req_idx  = mem_req_addr[MW+1:2];
  assign load_idx = load_addr[MW+1:2];
`ifdef WARP_MEM_STALL_EN
  logic [7:0] lfsr;
  // Free-running Fibonacci LFSR (taps 8,6,5,4) whose low bits inject request stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign stall = lfsr[1:0] == 2'b00;
`else
  assign stall = 1'b0;
`endif
  assign mem_req_ready  = (outstanding < CW'(QUEUE_DEPTH)) && !load_en && !rst && !stall;
  assign accept         = mem_req_valid && mem_req_ready;
  assign rd_acc         = accept && !mem_req_write;
  assign wr_acc         = accept && mem_req_write;
  assign rd_word        = req_oob ? OOB_WORD : mem[req_idx];
  assign mem_resp_valid = fcnt != '0;
  assign mem_resp_data  = mem_resp_valid ? fifo[rp] : '0;
  assign pop            = mem_resp_valid && mem_resp_ready;
  // Storage array: preload and in-range writes; contents survive reset
  always_ff @(posedge clk)
    if (load_en && !load_oob)    mem[load_idx] <= load_data;
    else if (wr_acc && !req_oob) mem[req_idx]  <= mem_req_data;
  // Read word is captured at acceptance, so LATENCY-1 register stages precede the queue
  if (LATENCY == 1) begin : g_direct
    assign push_v = rd_acc;
    assign push_d = rd_word;
  end else begin : g_pipe
    logic [LATENCY-1:1] sv;
    logic [31:0]        sd [LATENCY-1:1];
    // Valid bits of the read pipeline; cleared on reset to discard in-flight reads
    always_ff @(posedge clk or posedge rst)
      if (rst) sv <= '0;
      else begin
        sv[1] <= rd_acc;
        for (int i = 2; i < LATENCY; i++) sv[i] <= sv[i-1];
      end
    // Data payload of the read pipeline; qualified by sv so no reset needed
    always_ff @(posedge clk) begin
      sd[1] <= rd_word;
      for (int i = 2; i < LATENCY; i++) sd[i] <= sd[i-1];
    end
    assign push_v = sv[LATENCY-1];
    assign push_d = sd[LATENCY-1];
  end
  // Response queue payload; the outstanding limit guarantees a free slot on every push
  always_ff @(posedge clk)
    if (push_v) fifo[wp] <= push_d;
  // Queue pointers, occupancy, outstanding-read count and error pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rp          <= '0;
      wp          <= '0;
      fcnt        <= '0;
      outstanding <= '0;
      err_oob     <= 1'b0;
    end else begin
      if (push_v) wp <= wp == QW'(QUEUE_DEPTH - 1) ? '0 : wp + QW'(1);
      if (pop)    rp <= rp == QW'(QUEUE_DEPTH - 1) ? '0 : rp + QW'(1);
      fcnt        <= fcnt + CW'(push_v) - CW'(pop);
      outstanding <= outstanding + CW'(rd_acc) - CW'(pop);
      err_oob     <= (accept && req_oob) || (load_en && load_oob);
    end
endmodule
